// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier, W iterations per operation, signed or unsigned.
// Latency: W edges from the start-sampling edge to done; product held until the next completion.
module seq_multiplier #(
  parameter int W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   product
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [2*W-1:0]  mcand;
  logic [2*W-1:0]  acc;
  logic [W-1:0]    mplier;
  logic [CW-1:0]   cnt;
  logic            neg;

  logic [W-1:0]    a_mag;
  logic [W-1:0]    b_mag;
  logic [2*W-1:0]  acc_sum;
  logic [2*W-1:0]  acc_res;

  // Magnitude of the most negative value is 2^(W-1), which still fits as W-bit unsigned.
  assign a_mag   = (signed_mode && a[W-1]) ? -a : a;
  assign b_mag   = (signed_mode && b[W-1]) ? -b : b;
  assign acc_sum = acc + (mplier[0] ? mcand : '0);
  assign acc_res = neg ? -acc_sum : acc_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{W{1'b0}}, a_mag};
            mplier <= b_mag;
            neg    <= signed_mode & (a[W-1] ^ b[W-1]);
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) begin
            product <= acc_res;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at W=5 and W=8, plus a randomized W=8 sweep against a behavioural product.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start5, sm5, start8, sm8;
  logic [4:0]  a5, b5;
  logic [7:0]  a8, b8;
  logic        busy5, done5, busy8, done8;
  logic [9:0]  product5;
  logic [15:0] product8;

  int n_chk  = 0;
  int n_fail = 0;
  int dcnt5  = 0;
  int dcnt8  = 0;

  seq_multiplier #(.W(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .signed_mode(sm5),
    .a(a5), .b(b5), .busy(busy5), .done(done5), .product(product5)
  );

  seq_multiplier #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(product8)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done5) dcnt5++;
    if (done8) dcnt8++;
  end

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // garble: after the latch edge, scramble operands and hold start high through RUN/DONE
  task automatic op5(input logic [4:0] ta, input logic [4:0] tbv, input logic tsm,
                     input logic [9:0] exp, input string tag, input bit garble);
    int lat, bcnt, d0;
    @(negedge clk);
    d0 = dcnt5;
    a5 = ta; b5 = tbv; sm5 = tsm; start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    if (garble) begin
      a5 = ~ta; b5 = ~tbv; sm5 = ~tsm; start5 = 1'b1;
    end
    lat = 0; bcnt = 0;
    while (!done5 && lat < 40) begin
      if (busy5) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (busy5) bcnt++;
    chk(lat, 5, {tag, "_latency"});
    chk(product5, exp, {tag, "_product"});
    @(negedge clk);
    start5 = 1'b0;
    chk(busy5, 1'b0, {tag, "_busy_fall"});
    chk(done5, 1'b0, {tag, "_done_fall"});
    chk(bcnt, 6, {tag, "_busy_cycles"});
    repeat (3) @(negedge clk);
    chk(product5, exp, {tag, "_hold"});
    chk(dcnt5 - d0, 1, {tag, "_done_pulses"});
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tbv, input logic tsm,
                     input logic [15:0] exp, input string tag);
    int lat, bcnt, d0;
    @(negedge clk);
    d0 = dcnt8;
    a8 = ta; b8 = tbv; sm8 = tsm; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0; bcnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (busy8) bcnt++;
    chk(lat, 8, {tag, "_latency"});
    chk(product8, exp, {tag, "_product"});
    @(negedge clk);
    chk(busy8, 1'b0, {tag, "_busy_fall"});
    chk(bcnt, 9, {tag, "_busy_cycles"});
    chk(dcnt8 - d0, 1, {tag, "_done_pulses"});
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic        rs;
    logic [15:0] rexp;
    int          d0;

    rst = 1'b1;
    start5 = 1'b0; sm5 = 1'b0; a5 = '0; b5 = '0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    #1;
    chk(busy5, 1'b0, "reset_busy5");
    chk(done5, 1'b0, "reset_done5");
    chk(product5, 10'h000, "reset_product5");
    chk(product8, 16'h0000, "reset_product8");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle with start low: nothing may move
    repeat (20) @(negedge clk);
    chk(dcnt5, 0, "idle_no_done5");
    chk(busy5, 1'b0, "idle_busy5");
    chk(product5, 10'h000, "idle_product5");

    op5(5'd31, 5'd31, 1'b0, 10'h3C1, "umax5", 1'b0);
    op5(5'b11101, 5'b00111, 1'b1, 10'h3EB, "smix5", 1'b0);
    op5(5'b10000, 5'b10000, 1'b1, 10'h100, "sminmin5", 1'b0);
    op5(5'b01111, 5'b10000, 1'b1, 10'h310, "smaxmin5", 1'b0);
    op5(5'b11111, 5'b11111, 1'b1, 10'h001, "sneg1sq5", 1'b0);
    op5(5'd0, 5'd27, 1'b0, 10'h000, "zero5", 1'b0);
    op5(5'd3, 5'd5, 1'b0, 10'h00F, "garble5", 1'b1);

    // Abort an operation with an asynchronous reset in the middle of RUN
    @(negedge clk);
    d0 = dcnt5;
    a5 = 5'd19; b5 = 5'd23; sm5 = 1'b0; start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk(product5, 10'h000, "midrst_product5");
    chk(busy5, 1'b0, "midrst_busy5");
    chk(done5, 1'b0, "midrst_done5");
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk(dcnt5 - d0, 0, "midrst_no_done5");
    chk(product5, 10'h000, "midrst_product_after5");
    op5(5'd19, 5'd23, 1'b0, 10'h1B5, "retry5", 1'b0);

    op8(8'd255, 8'd255, 1'b0, 16'hFE01, "umax8");
    op8(8'h80, 8'h80, 1'b1, 16'h4000, "sminmin8");
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      if (rs)
        rexp = 16'($signed({{8{ra[7]}}, ra}) * $signed({{8{rb[7]}}, rb}));
      else
        rexp = 16'({8'h00, ra} * {8'h00, rb});
      op8(ra, rb, rs, rexp, "rand8");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-and-add multiplier with a start/done handshake and a selectable signed (two's-complement) mode. It succeeds the board-level combinational 5×5 array multiplier: the operand width is a parameter, the partial products are iterated over W clock cycles instead of a ripple adder chain, and the result is registered and held until the next operation. It sits between operand sources (switch inputs or a datapath) and the product consumer (LED drivers or downstream logic).

## Interface
- W, default 5: operand width in bits, legal range 2..16. Product width is 2W.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- signed_mode  input  1  1 = operands and product are two's complement; 0 = unsigned. Latched with start.
- a  input  W  multiplicand, latched with start.
- b  input  W  multiplier, latched with start.
- busy  output  1  high whenever the FSM is not IDLE.
- done  output  1  one-cycle pulse; product is valid from this cycle on.
- product  output  2W  registered result; held until overwritten by the next completed operation.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: on an edge with start=1, latch a, b, and signed_mode; clear the accumulator; set iteration counter to 0; go to RUN. start=0 keeps IDLE.
- Signed mode at latch: store operand magnitudes (|a|, |b| as W-bit unsigned; |−2^(W−1)| = 2^(W−1) fits) and neg = a[W−1] XOR b[W−1]. Unsigned mode: operands stored as-is, neg = 0.
- RUN, one iteration per edge: if multiplier LSB = 1, add multiplicand (shifted to current bit position) into the 2W-bit accumulator; shift multiplier right by 1; counter +1. No accumulator overflow is possible: max unsigned result (2^W−1)^2 < 2^(2W).
- On the W-th RUN edge (counter = W−1): write product = neg ? −(final accumulator) : final accumulator, computed modulo 2^(2W); go to DONE.
- DONE: done = 1 for exactly this cycle; next edge always returns to IDLE.
- start in RUN or DONE is ignored; no queuing. Changes to a, b, signed_mode after the latch edge have no effect on the running operation.
- Signed range check: (−2^(W−1))·(−2^(W−1)) = 2^(2W−2) is representable in 2W-bit two's complement; no saturation logic required.
- Reset (any time, including mid-RUN or DONE): state = IDLE, busy = 0, done = 0, product = 0, accumulator/counter/latched operands cleared. The aborted operation produces no done pulse and leaves product = 0.

## Timing
- Reset values: busy 0, done 0, product all-zero.
- Let edge E0 be the edge sampling start=1 in IDLE. busy rises after E0. Iterations occur on edges E0+1 … E0+W; product updates and done rises after E0+W; done falls and busy falls after E0+W+1.
- Latency start-sample to done: W edges. Minimum start-to-start interval: W+2 cycles (start may be held high; it is re-sampled in the first IDLE cycle).
- product is stable except at the single edge entering DONE and at reset.
- done and busy are register outputs; no combinational path from inputs to any output.

## Test plan
- Reset/idle: assert rst asynchronously between edges -> busy=0, done=0, product=0 immediately; with start=0 for 20 cycles no output changes.
- Unsigned max, W=5: a=31, b=31, signed_mode=0, start pulse -> done pulse exactly 5 edges after the sampling edge, product=961 (10'h3C1), busy high for 6 cycles.
- Signed mixed, W=5: a=5'b11101 (−3), b=5'b00111 (7), signed_mode=1 -> product=10'h3EB (−21); then a=5'b10000, b=5'b10000 -> product=256 (10'h100).
- Zero and hold: a=0, b=27 -> product=0; then change a, b, signed_mode during next RUN -> result matches latched values; product holds between operations; start asserted during RUN/DONE produces no extra done.
- Reset mid-operation: start a=19, b=23, assert rst at the third RUN cycle -> no done pulse, product=0, busy=0; after release a fresh a=19, b=23 gives 437.
- Parameter sweep, W=8: a=255, b=255 unsigned -> 16'hFE01 after 8 edges; randomized 1000 operations in both modes vs. a reference model, checking value and done timing.
